spi_flash_reader: RTL and testbench

//  SPI-mode-0 flash read initiator for the user project; drives the same 4-wire bus that spiflash models.

---
 rtl/spi_flash_reader.sv | 191 +++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//   SPI mode-0 flash read initiator. Accepts a (byte address, word count)
//   request, sends READ + 24-bit address MSB first, then streams the read
//   data back as little-endian 32-bit words through a one-word holding
//   register. If the holding register is still full when the next word
//   completes, SCK is parked low at the word boundary with CS held low.
//
//   Build option: define SPI_FAST_READ_EN to issue FAST READ (0x0B) with
//   8 dummy SCK cycles between address and data. Default is READ (0x03).
//
// Ports
//   clock, resetb          system clock, synchronous active-low reset
//   req_valid/req_ready    request handshake; req_addr, req_len latched on accept
//   rsp_valid/rsp_ready    response handshake; rsp_data word, rsp_last on final word
//   busy                   accept through end of CS idle time
//   done                   one-cycle pulse when CS rises (or on a zero-length accept)
//   flash_csb, flash_clk   chip select (active low), SCK (idles low)
//   flash_io0, flash_io1   MOSI, MISO
//
// state   | meaning
// S_IDLE  | CS high, waiting for request (req_ready once idle time elapsed)
// S_CMD   | shifting 8-bit opcode
// S_ADDR  | shifting 24-bit address
// S_DUMMY | 8 dummy SCK with io0 low (fast read build only)
// S_DATA  | receiving 32 bits per word, may park SCK low at a word boundary
// S_END   | trailing SCK-low time before CS rises
module spi_flash_reader #(
  parameter int CLK_DIV     = 2,
  parameter int LEN_W       = 8,
  parameter int CS_IDLE_CYC = 4
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             done,
  output logic             flash_csb,
  output logic             flash_clk,
  output logic             flash_io0,
  input  logic             flash_io1
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
  localparam logic       FAST   = 1'b1;
`else
  localparam logic [7:0] OPCODE = 8'h03;
  localparam logic       FAST   = 1'b0;
`endif

  localparam int DIV_W  = $clog2(2 * CLK_DIV) + 1;
  localparam int IDLE_W = $clog2(CS_IDLE_CYC + 1);
  localparam logic [DIV_W-1:0]  HALF_LD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  END_LD  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LD = IDLE_W'(CS_IDLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]  div_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [4:0]        bit_cnt, bit_ld;
  logic [LEN_W-1:0]  words_left;
  logic [31:0]       tx_sr, rx_sr;
  logic              sck, word_rdy, rdy_last, cs_wait;
  logic              accept, start, len0, shifting, stall, tick, rise, fall;
  logic              phase_end, last_word, end_done, data_done;

  assign accept    = req_valid & req_ready;
  assign start     = accept & (req_len != '0);
  assign len0      = accept & (req_len == '0);
  assign shifting  = (state == S_CMD) | (state == S_ADDR) | (state == S_DUMMY) | (state == S_DATA);
  // A completed word still waiting for the holding register freezes SCK low.
  assign stall     = (state == S_DATA) & ~sck & word_rdy;
  assign tick      = shifting & ~stall & (div_cnt == '0);
  assign rise      = tick & ~sck;
  assign fall      = tick & sck;
  assign phase_end = fall & (bit_cnt == 5'd0);
  assign last_word = (words_left == LEN_W'(1));
  assign data_done = phase_end & (state == S_DATA) & last_word;
  assign end_done  = (state == S_END) & (div_cnt == '0);

  assign req_ready = (state == S_IDLE) & (idle_cnt == '0);
  assign busy      = (state != S_IDLE) | (cs_wait & (idle_cnt != '0));
  assign flash_clk = sck;
  assign flash_io0 = tx_sr[31];

  always_comb begin
    state_nxt = state;
    bit_ld    = 5'd31;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CMD;
      S_CMD: begin
        bit_ld = 5'd23;
        if (phase_end) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        bit_ld = FAST ? 5'd7 : 5'd31;
        if (phase_end) state_nxt = FAST ? S_DUMMY : S_DATA;
      end
      S_DUMMY: if (phase_end) state_nxt = S_DATA;
      S_DATA:  if (data_done) state_nxt = S_END;
      S_END:   if (end_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state      <= S_IDLE;
      sck        <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      word_rdy   <= 1'b0;
      rdy_last   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_last   <= 1'b0;
      rsp_data   <= '0;
      flash_csb  <= 1'b1;
      done       <= 1'b0;
      idle_cnt   <= IDLE_LD;
      cs_wait    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;

      // END holds SCK low for a trailing half-bit plus CLK_DIV before CS rises.
      if (start)                                 div_cnt <= HALF_LD;
      else if (data_done)                        div_cnt <= END_LD;
      else if (tick)                             div_cnt <= HALF_LD;
      else if ((div_cnt != '0) && !stall)        div_cnt <= div_cnt - DIV_W'(1);

      if (tick) sck <= ~sck;

      if (start) begin
        bit_cnt    <= 5'd7;
        tx_sr      <= {OPCODE, req_addr};
        words_left <= req_len;
      end else if (fall) begin
        // zero fill keeps io0 low through dummy and data phases
        tx_sr   <= {tx_sr[30:0], 1'b0};
        bit_cnt <= (bit_cnt == 5'd0) ? bit_ld : bit_cnt - 5'd1;
        if (phase_end && (state == S_DATA) && !last_word)
          words_left <= words_left - LEN_W'(1);
      end

      if (rise && (state == S_DATA)) rx_sr <= {rx_sr[30:0], flash_io1};

      if (word_rdy && (!rsp_valid || rsp_ready)) begin
        rsp_data  <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
        rsp_valid <= 1'b1;
        rsp_last  <= rdy_last;
        word_rdy  <= 1'b0;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_last  <= 1'b0;
      end
      if (rise && (state == S_DATA) && (bit_cnt == 5'd0)) begin
        word_rdy <= 1'b1;
        rdy_last <= last_word;
      end

      if (start)         flash_csb <= 1'b0;
      else if (end_done) flash_csb <= 1'b1;

      if (end_done || len0) begin
        done     <= 1'b1;
        idle_cnt <= IDLE_LD;
        cs_wait  <= 1'b1;
      end else if (idle_cnt != '0) begin
        idle_cnt <= idle_cnt - IDLE_W'(1);
      end else begin
        cs_wait <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
`timescale 1ns/1ps
module tb_spi_flash_reader;
  localparam int CLK_DIV     = 2;
  localparam int LEN_W       = 8;
  localparam int CS_IDLE_CYC = 4;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] EXP_OP = 8'h0B;
  localparam int         OVH    = 40;
`else
  localparam logic [7:0] EXP_OP = 8'h03;
  localparam int         OVH    = 32;
`endif

  logic             clock = 1'b0;
  logic             resetb = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [23:0]      req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic             rsp_last;
  logic             busy, done;
  logic             flash_csb, flash_clk, flash_io0;
  logic             flash_io1 = 1'b0;

  always #5 clock = ~clock;

  spi_flash_reader #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .CS_IDLE_CYC(CS_IDLE_CYC)) dut (
    .clock(clock), .resetb(resetb),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .done(done),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0), .flash_io1(flash_io1)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // flash model: 256-byte array, address wraps on the low 8 bits
  logic [7:0]  mem [256];
  int          m_cnt = 0;
  logic [7:0]  m_op = '0;
  logic [23:0] m_addr = '0;
  int          io0_bad = 0;

  always @(negedge flash_csb or posedge flash_clk) begin
    if (!flash_clk) begin
      m_cnt  = 0;
      m_op   = '0;
      m_addr = '0;
    end else if (!flash_csb) begin
      if (m_cnt < 8)       m_op   = {m_op[6:0], flash_io0};
      else if (m_cnt < 32) m_addr = {m_addr[22:0], flash_io0};
      else if (flash_io0 !== 1'b0) io0_bad++;
      m_cnt++;
    end
  end

  always @(negedge flash_clk) begin
    int ds;
    int k;
    logic [7:0] b;
    ds = (m_op == 8'h0B) ? 40 : 32;
    if (!flash_csb && m_cnt >= ds) begin
      k = m_cnt - ds;
      b = mem[8'(m_addr + 24'(k / 8))];
      flash_io1 = b[7 - (k % 8)];
    end
  end

  function automatic logic [31:0] word_at(input logic [23:0] a);
    logic [7:0] i;
    i = a[7:0];
    return {mem[8'(i + 8'd3)], mem[8'(i + 8'd2)], mem[8'(i + 8'd1)], mem[i]};
  endfunction

  // scoreboard and bus monitor, sampled on the falling clock edge
  logic [32:0] sb [$];
  int          csb_low = 0;
  int          done_cnt = 0;
  int          rsp_v_cnt = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clock) begin
    logic [32:0] e;
    if (!flash_csb) csb_low++;
    if (done) done_cnt++;
    if (rsp_valid) rsp_v_cnt++;
    if (resetb) begin
      if (hold_prev) begin
        chk("hold_valid", 64'(rsp_valid), 64'd1);
        chk("hold_stable", 64'(rsp_data), 64'(prev_data));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(e[31:0]));
          chk("rsp_last", 64'(rsp_last), 64'(e[32]));
        end
      end
    end
    hold_prev = rsp_valid && !rsp_ready && resetb;
    prev_data = rsp_data;
  end

  task automatic do_req(input logic [23:0] a, input int n);
    int t;
    t = 0;
    for (int i = 0; i < n; i++) sb.push_back({(i == n - 1), word_at(a + 24'(4 * i))});
    @(posedge clock); #1;
    req_addr  = a;
    req_len   = LEN_W'(n);
    req_valid = 1'b1;
    while (!req_ready && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 2000) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int t;
    t = 0;
    while (done_cnt == base && t < budget) begin
      @(negedge clock);
      t++;
    end
    repeat (6) @(negedge clock);
    chk("done_pulses", 64'(done_cnt - base), 64'd1);
  endtask

  task automatic wait_sb(input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge clock);
      t++;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_rsp_valid(input int budget);
    int t;
    t = 0;
    while (!rsp_valid && t < budget) begin
      @(negedge clock);
      t++;
    end
    chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, c0, b0, v0, t;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    mem[4] = 8'h93; mem[5] = 8'h05; mem[6] = 8'h20; mem[7] = 8'h00;
    mem[252] = 8'hEF; mem[253] = 8'hBE; mem[254] = 8'hAD; mem[255] = 8'hDE;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_csb", 64'(flash_csb), 64'd1);
    chk("rst_sck", 64'(flash_clk), 64'd0);
    chk("rst_io0", 64'(flash_io0), 64'd0);
    chk("rst_ctl", 64'({req_ready, rsp_valid, rsp_last, busy, done}), 64'd0);
    chk("rst_data", 64'(rsp_data), 64'd0);
    resetb = 1'b1;

    // one word at 0, consumer always ready
    rsp_ready = 1'b1;
    d0 = done_cnt; c0 = csb_low; b0 = io0_bad;
    do_req(24'h000000, 1);
    chk("busy_after_accept", 64'(busy), 64'd1);
    wait_done(d0, 2000);
    wait_sb(500);
    chk("t1_opcode", 64'(m_op), 64'(EXP_OP));
    chk("t1_addr", 64'(m_addr), 64'h0);
    chk("t1_sck_rises", 64'(m_cnt), 64'(OVH + 32));
    chk("t1_csb_low_clks", 64'(csb_low - c0), 64'((OVH + 32) * 2 * CLK_DIV + 2 * CLK_DIV));
    chk("t1_io0_zero", 64'(io0_bad - b0), 64'd0);
    repeat (CS_IDLE_CYC + 2) @(negedge clock);
    chk("t1_idle_ready", 64'({req_ready, busy}), 64'b10);

    // two words, consumer stalled 200 clocks after first word
    rsp_ready = 1'b0;
    d0 = done_cnt;
    do_req(24'h000000, 2);
    wait_rsp_valid(2000);
    repeat (200) @(negedge clock);
    chk("t2_data_rises", 64'(m_cnt - OVH), 64'd64);
    chk("t2_csb_high", 64'(flash_csb), 64'd1);
    chk("t2_done_before_drain", 64'(done_cnt - d0), 64'd1);
    chk("t2_nothing_popped", 64'(sb.size()), 64'd2);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    wait_sb(500);
    chk("t2_done_total", 64'(done_cnt - d0), 64'd1);

    // three words: SCK must park low with CS low after the second word
    rsp_ready = 1'b0;
    d0 = done_cnt;
    do_req(24'h000000, 3);
    wait_rsp_valid(2000);
    repeat (200) @(negedge clock);
    chk("t3_stall_rises", 64'(m_cnt - OVH), 64'd64);
    chk("t3_stall_bus", 64'({flash_csb, flash_clk}), 64'b00);
    chk("t3_no_done_yet", 64'(done_cnt - d0), 64'd0);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    wait_done(d0, 2000);
    wait_sb(500);
    chk("t3_data_rises", 64'(m_cnt - OVH), 64'd96);

    // one word at the array end
    d0 = done_cnt;
    do_req(24'h0000FC, 1);
    wait_done(d0, 2000);
    wait_sb(500);
    chk("t4_addr", 64'(m_addr), 64'h0000FC);

    // zero-length request
    d0 = done_cnt; c0 = csb_low; v0 = rsp_v_cnt;
    do_req(24'h000010, 0);
    chk("len0_done_next", 64'(done), 64'd1);
    chk("len0_busy", 64'(busy), 64'd1);
    repeat (10) @(negedge clock);
    chk("len0_no_csb", 64'(csb_low - c0), 64'd0);
    chk("len0_one_done", 64'(done_cnt - d0), 64'd1);
    chk("len0_no_rsp", 64'(rsp_v_cnt - v0), 64'd0);

    // reset in the middle of the address phase
    d0 = done_cnt;
    do_req(24'h000000, 1);
    t = 0;
    while (m_cnt < 16 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    chk("rst_mid_reached_addr", 64'(m_cnt >= 16 && m_cnt < 32), 64'd1);
    @(posedge clock); #1;
    resetb = 1'b0;
    @(posedge clock); #1;
    chk("rst_mid_bus", 64'({flash_csb, flash_clk}), 64'b10);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    resetb = 1'b1;
    sb.delete();
    repeat (2) @(negedge clock);
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    d0 = done_cnt;
    do_req(24'h000004, 1);
    wait_done(d0, 2000);
    wait_sb(500);
    chk("t6_addr", 64'(m_addr), 64'h000004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
